// File: rtl/keypad_pkg.sv
// Shared constants, frame-class type and the frame classifier for the keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_KEY   = 2'd1,
    CLS_MULTI = 2'd2
  } frame_cls_t;

  typedef enum logic {
    SEQ_ROW  = 1'b0,
    SEQ_EVAL = 1'b1
  } seq_state_t;

  // Class plus key code; code is zero for NONE and MULTI so whole-struct
  // equality is the "same frame" test used by the debouncer.
  typedef struct packed {
    frame_cls_t       cls;
    logic [KEY_W-1:0] code;
  } frame_t;

  // hits[r*NUM_COLS + c] set when key (r,c) is pressed; bit index equals {r,c}.
  function automatic frame_t classify(input logic [NUM_KEYS-1:0] hits);
    frame_t f;
    int     n;
    f.cls  = CLS_NONE;
    f.code = '0;
    n      = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (hits[i]) begin
        n      = n + 1;
        f.code = KEY_W'(i);
      end
    end
    if (n == 1) begin
      f.cls = CLS_KEY;
    end else if (n > 1) begin
      f.cls  = CLS_MULTI;
      f.code = '0;
    end
    return f;
  endfunction

endpackage

// File: rtl/keypad_row_seq.sv
// Row sequencer: drives one row at a time, captures the columns at the end of
// each row slot and presents the classified frame during the one-cycle EVAL state.
module keypad_row_seq
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col_sync_n,
  output logic [NUM_ROWS-1:0] row_drv,
  output seq_state_t          seq_state,
  output frame_t              frame
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(NUM_ROWS);

  logic                running;
  logic [ROW_W-1:0]    row;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_KEYS-1:0] hits;
  logic [NUM_KEYS-1:0] hits_now;
  logic                sample;

  // Current row's pressed columns merged into the frame captured so far.
  always_comb begin
    hits_now = hits;
    hits_now[{row, 2'b00} +: NUM_COLS] = ~col_sync_n;
    sample = running && (seq_state == SEQ_ROW) && (cnt == CNT_W'(SCAN_DIV - 1));
  end

  // Sequencer FSM: the first cycle out of reset arms row 0, so row_drv is
  // zero throughout reset and row 0 is driven from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b0;
      seq_state <= SEQ_ROW;
      row       <= '0;
      cnt       <= '0;
      row_drv   <= '0;
      hits      <= '0;
      frame     <= '0;
    end else if (!running) begin
      running <= 1'b1;
      row_drv <= NUM_ROWS'(1);
    end else if (seq_state == SEQ_EVAL) begin
      seq_state <= SEQ_ROW;
      row       <= '0;
      cnt       <= '0;
      row_drv   <= NUM_ROWS'(1);
    end else if (sample) begin
      hits <= hits_now;
      if (row == ROW_W'(NUM_ROWS - 1)) begin
        seq_state <= SEQ_EVAL;
        row_drv   <= '0;
        frame     <= classify(hits_now);
      end else begin
        row     <= row + 1'b1;
        cnt     <= '0;
        row_drv <= row_drv << 1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronizes columns, debounces whole frames and hands
// one key code per stable press to the consumer.
//
// Handshake: key_code is presented while key_valid is high and is transferred
// on every rising clk edge where key_valid && key_ready; key_valid then drops
// unless a new key is loaded on that same edge. key_code never changes while
// key_valid is high and the key has not been taken.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_ROWS-1:0] row_drv,
  input  logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_down,
  output logic                overflow
);

  localparam int                STAB_W   = $clog2(DEBOUNCE + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);

  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] col_sync_n;
  seq_state_t          seq_state;
  frame_t              frame;
  frame_t              cand;
  logic [STAB_W-1:0]   stab_cnt;
  logic [STAB_W-1:0]   stab_next;
  logic                frame_evt;
  logic                same;
  logic                fire;
  logic                emit;
  logic                take;

  keypad_row_seq #(
    .SCAN_DIV (SCAN_DIV)
  ) u_row_seq (
    .clk        (clk),
    .rst        (rst),
    .col_sync_n (col_sync_n),
    .row_drv    (row_drv),
    .seq_state  (seq_state),
    .frame      (frame)
  );

  // Two-flop column synchronizer; the zeroed value after reset is flushed
  // long before the first sample point of row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta   <= '0;
      col_sync_n <= '0;
    end else begin
      col_meta   <= col_n;
      col_sync_n <= col_meta;
    end
  end

  // Debounce decision for the frame on offer; fires only on the edge where
  // the stability count first reaches DEBOUNCE.
  always_comb begin
    frame_evt = (seq_state == SEQ_EVAL);
    same      = (frame == cand);
    if (!same) begin
      stab_next = STAB_W'(1);
    end else if (stab_cnt == STAB_MAX) begin
      stab_next = stab_cnt;
    end else begin
      stab_next = stab_cnt + 1'b1;
    end
    fire = frame_evt && (stab_next == STAB_MAX) && !(same && (stab_cnt == STAB_MAX));
    emit = fire && (frame.cls == CLS_KEY) && !key_down;
    take = key_valid && key_ready;
  end

  // Candidate tracking and the debounced key_down level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand     <= '0;
      stab_cnt <= '0;
      key_down <= 1'b0;
    end else if (frame_evt) begin
      cand     <= frame;
      stab_cnt <= stab_next;
      if (fire && (frame.cls == CLS_KEY)) begin
        key_down <= 1'b1;
      end else if (fire && (frame.cls == CLS_NONE)) begin
        key_down <= 1'b0;
      end
    end
  end

  // One-entry holding register; a key arriving while it is full is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!key_valid || take) begin
        key_code  <= frame.code;
        key_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (take) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_n from row_drv,
// a frame-level behavioural model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_drv;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic       overflow;

  logic [15:0] keys       = '0;
  logic        col_force  = 1'b0;
  bit          rand_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  // Behavioural model state: cycle index within the scan timeline and frame-level debounce.
  int          m_t     = -1;
  int          m_cand  = -1;
  int          m_run   = 0;
  int          m_cls   = -1;
  bit          m_armed = 1'b0;
  bit          m_down  = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_emit  = 1'b0;
  bit          m_take  = 1'b0;
  logic [3:0]  m_code  = '0;
  logic [3:0]  m_ec    = '0;
  logic [15:0] m_frame_keys = '0;
  logic [3:0]  exp_row;

  // Clock and reset
  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_drv   (row_drv),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overflow  (overflow)
  );

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row_drv[r] && keys[r*4+c]) col_n[c] = 1'b0;
      end
    end
    if (col_force) col_n = 4'h0;
  end

  // -1 = no key, 0..15 = single key code, 16 = several keys.
  function automatic int frame_class(input logic [15:0] k);
    if (k == 16'h0) return -1;
    if ($countones(k) > 1) return 16;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) return i;
    end
    return -1;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0d time=%0t", name, act, exp, m_t, $time);
    end
  endtask

  // Reference model, advanced once per clock edge from the inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1'b1;
      m_t     = -1;
      m_cand  = -1;
      m_run   = 0;
      m_down  = 1'b0;
      m_valid = 1'b0;
      m_code  = '0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else if (m_armed) begin
      m_emit = 1'b0;
      m_ec   = '0;
      m_take = m_valid && key_ready;
      if (m_t >= 0 && (m_t % FRAME) == FRAME - 1) begin
        m_cls = frame_class(m_frame_keys);
        if (m_cls == m_cand) begin
          m_run++;
        end else begin
          m_cand = m_cls;
          m_run  = 1;
        end
        if (m_run == DEBOUNCE) begin
          if (m_cls >= 0 && m_cls < 16 && !m_down) begin
            m_down = 1'b1;
            m_emit = 1'b1;
            m_ec   = m_cls[3:0];
          end else if (m_cls < 0) begin
            m_down = 1'b0;
          end
        end
      end
      if (m_emit) begin
        if (!m_valid || m_take) begin
          m_code  = m_ec;
          m_valid = 1'b1;
          exp_q.push_back(m_ec);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_take) begin
        m_valid = 1'b0;
      end
      m_t++;
      if ((m_t % FRAME) == 0) m_frame_keys = keys;
    end
  end

  // Scoreboard: every output against the model each cycle, plus each handed-over key.
  always @(negedge clk) begin
    if (m_armed) begin
      exp_row = (m_t >= 0 && (m_t % FRAME) < FRAME - 1) ? 4'(1 << ((m_t % FRAME) / SCAN_DIV)) : 4'h0;
      cmp("row_drv", row_drv, exp_row);
      cmp("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      cmp("key_code", key_code, m_code);
      cmp("key_down", {3'b0, key_down}, {3'b0, m_down});
      cmp("overflow", {3'b0, overflow}, {3'b0, m_ovf});
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_key actual=%h required=none time=%0t", key_code, $time);
        end else begin
          cmp("sb_code", key_code, exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #2;
    if (rand_ready) key_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_eval();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_t >= 0 && (m_t % FRAME) == FRAME - 1) && n < 2 * FRAME);
    if (!(m_t >= 0 && (m_t % FRAME) == FRAME - 1)) begin
      checks++;
      failures++;
      $display("FAIL wait_eval timeout actual=%0d required=%0d", m_t % FRAME, FRAME - 1);
    end
  endtask

  // Hold key set k for n whole frames; keys only change in EVAL or reset cycles.
  task automatic run_frames(input logic [15:0] k, input int n);
    if (!(m_t < 0 || (m_t % FRAME) == FRAME - 1)) wait_eval();
    keys = k;
    repeat (n) wait_eval();
  endtask

  task automatic chk_all_zero(input string tag);
    cmp({tag, "_row_drv"}, row_drv, 4'h0);
    cmp({tag, "_key_code"}, key_code, 4'h0);
    cmp({tag, "_key_valid"}, {3'b0, key_valid}, 4'h0);
    cmp({tag, "_key_down"}, {3'b0, key_down}, 4'h0);
    cmp({tag, "_overflow"}, {3'b0, overflow}, 4'h0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios, then randomized frames
  initial begin
    int sel;
    int n;
    logic [15:0] k;

    // Reset with all columns forced low.
    col_force = 1'b1;
    rst       = 1'b1;
    repeat (3) step();
    at_neg();
    chk_all_zero("reset");
    rst       = 1'b0;
    col_force = 1'b0;
    step();
    at_neg();
    cmp("first_row", row_drv, 4'b0001);
    repeat (4) step();
    at_neg();
    cmp("second_row", row_drv, 4'b0010);
    wait_eval();

    // Row 2 col 1 held: code 9 one cycle after the third EVAL.
    run_frames(16'h1 << 9, 3);
    at_neg();
    cmp("k9_not_yet", {3'b0, key_valid}, 4'h0);
    step();
    key_ready = 1'b1;
    at_neg();
    cmp("k9_valid", {3'b0, key_valid}, 4'h1);
    cmp("k9_code", key_code, 4'd9);
    step();
    key_ready = 1'b0;
    at_neg();
    cmp("k9_taken", {3'b0, key_valid}, 4'h0);
    repeat (3) wait_eval();
    at_neg();
    cmp("k9_no_repeat", {3'b0, key_valid}, 4'h0);
    cmp("k9_down", {3'b0, key_down}, 4'h1);
    run_frames(16'h0, 3);
    step();
    at_neg();
    cmp("k9_released", {3'b0, key_down}, 4'h0);

    // Bounce on key 5.
    run_frames(16'h1 << 5, 2);
    run_frames(16'h0, 1);
    run_frames(16'h1 << 5, 3);
    step();
    key_ready = 1'b1;
    at_neg();
    cmp("k5_valid", {3'b0, key_valid}, 4'h1);
    cmp("k5_code", key_code, 4'd5);
    step();
    key_ready = 1'b0;
    run_frames(16'h0, 3);

    // Two keys together, then one released leaves key 7.
    run_frames((16'h1 << 0) | (16'h1 << 7), 3);
    step();
    at_neg();
    cmp("multi_no_emit", {3'b0, key_valid}, 4'h0);
    cmp("multi_not_down", {3'b0, key_down}, 4'h0);
    run_frames(16'h1 << 7, 3);
    step();
    key_ready = 1'b1;
    at_neg();
    cmp("k7_valid", {3'b0, key_valid}, 4'h1);
    cmp("k7_code", key_code, 4'd7);
    step();
    key_ready = 1'b0;
    run_frames(16'h0, 3);

    // Overflow: key 1 pending, key 2 dropped.
    run_frames(16'h1 << 1, 3);
    run_frames(16'h0, 3);
    run_frames(16'h1 << 2, 3);
    step();
    at_neg();
    cmp("ovf_code_kept", key_code, 4'd1);
    cmp("ovf_set", {3'b0, overflow}, 4'h1);
    step();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    at_neg();
    cmp("ovf_taken", {3'b0, key_valid}, 4'h0);
    cmp("ovf_sticky", {3'b0, overflow}, 4'h1);
    run_frames(16'h0, 3);

    // Reset in the middle of row 2 with a key pending; the held key re-emits.
    run_frames(16'h1 << 14, 3);
    step();
    at_neg();
    cmp("k14_valid", {3'b0, key_valid}, 4'h1);
    n = 0;
    while ((m_t % FRAME) != 10 && n < 2 * FRAME) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    at_neg();
    chk_all_zero("midrst");
    rst = 1'b0;
    step();
    at_neg();
    cmp("midrst_row0", row_drv, 4'b0001);
    repeat (3) wait_eval();
    at_neg();
    cmp("k14_fresh_wait", {3'b0, key_valid}, 4'h0);
    step();
    key_ready = 1'b1;
    at_neg();
    cmp("k14_reemit", {3'b0, key_valid}, 4'h1);
    cmp("k14_code", key_code, 4'd14);
    step();
    key_ready = 1'b0;
    run_frames(16'h0, 3);

    // Randomized frame sequences with random consumer back-pressure.
    rand_ready = 1'b1;
    repeat (40) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2) k = 16'h0;
      else if (sel <= 7) k = 16'h1 << $urandom_range(0, 15);
      else if (sel == 8) k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else k = 16'($urandom());
      run_frames(k, $urandom_range(1, 4));
    end
    rand_ready = 1'b0;
    step();
    key_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
